// File: rtl/axilite_regfile_slave.sv
// AXI4-Lite slave over a flop-based register file with a parallel hardware view of every register.
// Optional privilege check on the upper register region is enabled by defining AXIL_PROT_CHECK_EN.
module axilite_regfile_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    PRIV_BASE  = DEPTH / 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       s_awaddr,
    input  logic [2:0]                  s_awprot,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [ADDR_WIDTH-1:0]       s_araddr,
    input  logic [2:0]                  s_arprot,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [DATA_WIDTH-1:0]       s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [DEPTH*DATA_WIDTH-1:0] regs_o,
    output logic [DEPTH-1:0]            wr_pulse_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int RIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // write-side holding registers
    logic                    aw_held;
    logic [IDX_W-1:0]        aw_idx;
    logic                    aw_priv;
    logic                    w_held;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic                    b_valid;
    logic [1:0]              b_resp;

    // read-side response registers
    logic                    r_valid;
    logic [1:0]              r_resp;
    logic [DATA_WIDTH-1:0]   r_data;

    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
    logic [DEPTH-1:0]        wr_pulse_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    commit;
    logic [IDX_W-1:0]        ar_idx;
    logic                    w_in_range;
    logic                    ar_in_range;
    logic                    w_ok;
    logic                    ar_ok;
    logic [RIDX_W-1:0]       w_ridx;
    logic [RIDX_W-1:0]       r_ridx;
    logic                    unused_sigs;

    assign s_awready = ~aw_held;
    assign s_wready  = ~w_held;
    assign s_arready = ~r_valid | s_rready;

    assign aw_hs  = s_awvalid & ~aw_held;
    assign w_hs   = s_wvalid & ~w_held;
    assign ar_hs  = s_arvalid & s_arready;
    // a pending response blocks the next commit until the master takes it
    assign commit = aw_held & w_held & (~b_valid | s_bready);

    assign ar_idx      = s_araddr[ADDR_WIDTH-1:OFF_W];
    assign w_in_range  = {1'b0, aw_idx} < DEPTH_L;
    assign ar_in_range = {1'b0, ar_idx} < DEPTH_L;
    assign w_ridx      = aw_idx[RIDX_W-1:0];
    assign r_ridx      = ar_idx[RIDX_W-1:0];

`ifdef AXIL_PROT_CHECK_EN
    localparam logic [IDX_W:0] PRIV_L = (IDX_W + 1)'(PRIV_BASE);
    assign w_ok  = w_in_range  & (aw_priv     | ({1'b0, aw_idx} < PRIV_L));
    assign ar_ok = ar_in_range & (s_arprot[0] | ({1'b0, ar_idx} < PRIV_L));
    assign unused_sigs = ^{s_awprot[2:1], s_arprot[2:1],
                           s_awaddr[OFF_W-1:0], s_araddr[OFF_W-1:0]};
`else
    assign w_ok  = w_in_range;
    assign ar_ok = ar_in_range;
    assign unused_sigs = ^{s_awprot[2:1], s_arprot, aw_priv,
                           s_awaddr[OFF_W-1:0], s_araddr[OFF_W-1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            aw_idx  <= '0;
            aw_priv <= 1'b0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            b_valid <= 1'b0;
            b_resp  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (b_valid && s_bready) begin
                b_valid <= 1'b0;
            end
            // capture only while empty, so this never collides with commit
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_awaddr[ADDR_WIDTH-1:OFF_W];
                aw_priv <= s_awprot[0];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (commit && w_ok) begin
                // pulse even with an all-zero strobe: the access itself is the event
                wr_pulse_q[w_ridx] <= 1'b1;
                for (int k = 0; k < STRB_W; k++) begin
                    if (w_strb[k]) begin
                        regs_q[w_ridx][8*k +: 8] <= w_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // reads sample the flops before any same-edge write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_valid <= 1'b1;
                r_data  <= ar_ok ? regs_q[r_ridx] : '0;
                r_resp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_rready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign s_bvalid   = b_valid;
    assign s_bresp    = b_resp;
    assign s_rvalid   = r_valid;
    assign s_rdata    = r_data;
    assign s_rresp    = r_resp;
    assign wr_pulse_o = wr_pulse_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_regs_view
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axilite_regfile_slave.sv
// Randomised self-checking bench for axilite_regfile_slave against an array-based register model.
// Protection expectations follow AXIL_PROT_CHECK_EN when it is defined for the build.
module tb_axilite_regfile_slave;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   s_awaddr;
    logic [2:0]      s_awprot;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   s_araddr;
    logic [2:0]      s_arprot;
    logic            s_arvalid;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic [DEPTH*DW-1:0] regs_o;
    logic [DEPTH-1:0]    wr_pulse_o;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [DEPTH];

    axilite_regfile_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_resp(input int idx, input logic priv);
        if (idx >= DEPTH) return 2'b10;
`ifdef AXIL_PROT_CHECK_EN
        if (!priv && idx >= DEPTH / 2) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < DW / 8; k++) if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
        return r;
    endfunction

    function automatic logic [DEPTH*DW-1:0] model_flat();
        logic [DEPTH*DW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic bus_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, input logic [2:0] prot,
                             output logic [1:0] resp, output logic [DEPTH-1:0] pulse,
                             output bit timeout);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        @(negedge clk);
        s_awaddr = addr; s_awprot = prot; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; s_bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_wvalid = 1'b0;  w_done = 1;  end
        end
        while (!s_bvalid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        timeout = !s_bvalid;
        resp = s_bresp;
        pulse = wr_pulse_o;
    endtask

    task automatic bus_read(input logic [AW-1:0] addr, input logic [2:0] prot,
                            output logic [DW-1:0] data, output logic [1:0] resp, output bit timeout);
        bit hs, done;
        int cyc;
        done = 0; cyc = 0;
        @(negedge clk);
        s_araddr = addr; s_arprot = prot; s_arvalid = 1'b1; s_rready = 1'b1;
        while (!done && cyc < 20) begin
            hs = s_arvalid && s_arready;
            @(negedge clk);
            cyc++;
            if (hs) done = 1;
        end
        s_arvalid = 1'b0;
        timeout = !s_rvalid;
        data = s_rdata;
        resp = s_rresp;
    endtask

    task automatic test_reset();
        checks++;
        if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_valids: bvalid=%b rvalid=%b bresp=%b rresp=%b, required 0 0 00 00",
                     s_bvalid, s_rvalid, s_bresp, s_rresp);
        end
        checks++;
        if (s_rdata !== '0 || wr_pulse_o !== '0 || regs_o !== model_flat()) begin
            errors++;
            $display("FAIL reset_data: rdata=%h pulse=%h regs_o mismatch=%b", s_rdata, wr_pulse_o,
                     regs_o !== model_flat());
        end
        checks++;
        if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: awready=%b wready=%b arready=%b, required 1 1 1",
                     s_awready, s_wready, s_arready);
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [DEPTH-1:0] pulse; logic [DW-1:0] rd; bit to;
        bus_write(32'h0, 32'hDEADBEEF, 4'hF, 3'b001, resp, pulse, to);
        model[0] = 32'hDEADBEEF;
        checks++;
        if (to || resp !== 2'b00 || pulse !== 16'h0001) begin
            errors++;
            $display("FAIL basic_write: timeout=%0b bresp=%b pulse=%h, required 0 00 0001", to, resp, pulse);
        end
        @(negedge clk);
        checks++;
        if (wr_pulse_o !== 16'h0) begin
            errors++;
            $display("FAIL basic_pulse_width: pulse=%h, required 0000", wr_pulse_o);
        end
        bus_read(32'h0, 3'b001, rd, resp, to);
        checks++;
        if (to || rd !== 32'hDEADBEEF || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read: timeout=%0b rdata=%h rresp=%b, required 0 deadbeef 00", to, rd, resp);
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        s_wdata = 32'hCAFEBABE; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_wready !== 1'b0 || s_bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_first_hold[%0d]: wready=%b bvalid=%b, required 0 0", i, s_wready, s_bvalid);
            end
            if (i < 2) @(negedge clk);
        end
        s_awaddr = 32'h10; s_awprot = 3'b001; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_first_early_b: bvalid=%b, required 0", s_bvalid);
        end
        @(negedge clk);
        model[4] = 32'hCAFEBABE;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || wr_pulse_o !== 16'h0010 || regs_o !== model_flat()) begin
            errors++;
            $display("FAIL w_first_commit: bvalid=%b bresp=%b pulse=%h reg4=%h, required 1 00 0010 cafebabe",
                     s_bvalid, s_bresp, wr_pulse_o, regs_o[4*DW +: DW]);
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp; logic [DEPTH-1:0] pulse; logic [DW-1:0] rd; bit to;
        bus_write(32'h20, 32'hFFFFFFFF, 4'hF, 3'b001, resp, pulse, to);
        model[8] = 32'hFFFFFFFF;
        bus_write(32'h20, 32'h12345678, 4'h1, 3'b001, resp, pulse, to);
        model[8] = merge(model[8], 32'h12345678, 4'h1);
        bus_read(32'h20, 3'b001, rd, resp, to);
        checks++;
        if (to || rd !== 32'hFFFFFF78 || rd !== model[8] || resp !== 2'b00) begin
            errors++;
            $display("FAIL strobe_merge: rdata=%h rresp=%b, required ffffff78 00", rd, resp);
        end
        bus_write(32'h20, 32'h0, 4'h0, 3'b001, resp, pulse, to);
        checks++;
        if (to || resp !== 2'b00 || pulse !== 16'h0100 || regs_o !== model_flat()) begin
            errors++;
            $display("FAIL strobe_zero: bresp=%b pulse=%h reg8=%h, required 00 0100 %h",
                     resp, pulse, regs_o[8*DW +: DW], model[8]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [DEPTH-1:0] pulse; logic [DW-1:0] rd; bit to;
        bus_read(32'hFFFFFFFC, 3'b001, rd, resp, to);
        checks++;
        if (to || rd !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL oor_read: rdata=%h rresp=%b, required 00000000 10", rd, resp);
        end
        bus_write(32'hFFFFFFFC, 32'h55AA55AA, 4'hF, 3'b001, resp, pulse, to);
        checks++;
        if (to || resp !== 2'b10 || pulse !== 16'h0 || regs_o !== model_flat()) begin
            errors++;
            $display("FAIL oor_write: bresp=%b pulse=%h regs_changed=%b, required 10 0000 0",
                     resp, pulse, regs_o !== model_flat());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; logic [DEPTH-1:0] pulse; bit to;
        for (int i = 0; i < 4; i++) begin
            model[i] = $urandom;
            bus_write(AW'(i * 4), model[i], 4'hF, 3'b001, resp, pulse, to);
        end
        @(negedge clk);
        s_rready = 1'b1; s_arprot = 3'b001; s_araddr = 32'h0; s_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_arready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_arready[%0d]: arready=%b, required 1", i, s_arready);
            end
            @(negedge clk);
            if (i < 3) s_araddr = AW'((i + 1) * 4);
            else s_arvalid = 1'b0;
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== model[i] || s_rresp !== 2'b00) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: rvalid=%b rdata=%h rresp=%b, required 1 %h 00",
                         i, s_rvalid, s_rdata, s_rresp, model[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rvalid=%b, required 0", s_rvalid);
        end
    endtask

    task automatic test_b_stall();
        logic [DW-1:0] d1, d2;
        d1 = $urandom; d2 = $urandom;
        @(negedge clk);
        s_bready = 1'b0;
        s_awaddr = 32'h8; s_awprot = 3'b001; s_awvalid = 1'b1;
        s_wdata = d1; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        model[2] = d1;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || wr_pulse_o !== 16'h0004 || regs_o !== model_flat()) begin
            errors++;
            $display("FAIL stall_first: bvalid=%b bresp=%b pulse=%h, required 1 00 0004",
                     s_bvalid, s_bresp, wr_pulse_o);
        end
        s_awaddr = 32'hC; s_awvalid = 1'b1; s_wdata = d2; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || wr_pulse_o !== 16'h0 ||
                regs_o !== model_flat() || s_awready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: bvalid=%b bresp=%b pulse=%h awready=%b reg3=%h, required 1 00 0000 0 %h",
                         i, s_bvalid, s_bresp, wr_pulse_o, s_awready, regs_o[3*DW +: DW], model[3]);
            end
            if (i < 4) @(negedge clk);
        end
        s_bready = 1'b1;
        @(negedge clk);
        model[3] = d2;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || wr_pulse_o !== 16'h0008 || regs_o !== model_flat()) begin
            errors++;
            $display("FAIL stall_second: bvalid=%b bresp=%b pulse=%h reg3=%h, required 1 00 0008 %h",
                     s_bvalid, s_bresp, wr_pulse_o, regs_o[3*DW +: DW], d2);
        end
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: bvalid=%b, required 0", s_bvalid);
        end
    endtask

    task automatic test_prot();
        logic [1:0] resp, er; logic [DEPTH-1:0] pulse; logic [DW-1:0] rd, d; bit to;
        for (int p = 0; p < 2; p++) begin
            d = $urandom;
            bus_write(32'h20, d, 4'hF, 3'(p), resp, pulse, to);
            er = exp_resp(8, p[0]);
            if (er == 2'b00) model[8] = d;
            checks++;
            if (to || resp !== er || pulse !== ((er == 2'b00) ? 16'h0100 : 16'h0) || regs_o !== model_flat()) begin
                errors++;
                $display("FAIL prot_write[%0d]: bresp=%b pulse=%h reg8=%h, required %b reg8=%h",
                         p, resp, pulse, regs_o[8*DW +: DW], er, model[8]);
            end
            bus_read(32'h20, 3'(p), rd, resp, to);
            checks++;
            if (to || resp !== er || rd !== ((er == 2'b00) ? model[8] : 32'h0)) begin
                errors++;
                $display("FAIL prot_read[%0d]: rdata=%h rresp=%b, required resp %b", p, rd, resp, er);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, er; logic [DEPTH-1:0] pulse; logic [DW-1:0] rd, d;
        logic [3:0] strb; logic [2:0] prot; int idx; bit to;
        for (int n = 0; n < 60; n++) begin
            idx  = $urandom_range(0, DEPTH + 3);
            prot = 3'($urandom_range(0, 7));
            er   = exp_resp(idx, prot[0]);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                strb = 4'($urandom_range(0, 15));
                bus_write(AW'(idx * 4), d, strb, prot, resp, pulse, to);
                if (er == 2'b00) model[idx] = merge(model[idx], d, strb);
                checks++;
                if (to || resp !== er || pulse !== ((er == 2'b00) ? (16'h1 << idx) : 16'h0) ||
                    regs_o !== model_flat()) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: idx=%0d bresp=%b pulse=%h timeout=%0b, required %b",
                             n, idx, resp, pulse, to, er);
                end
            end else begin
                bus_read(AW'(idx * 4), prot, rd, resp, to);
                checks++;
                if (to || resp !== er || rd !== ((er == 2'b00) ? model[idx] : 32'h0)) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: idx=%0d rdata=%h rresp=%b, required %h %b", n, idx, rd, resp,
                             (er == 2'b00) ? model[idx] : 32'h0, er);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        s_bready = 1'b1;
        s_awaddr = 32'h4; s_awprot = 3'b001; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        checks++;
        if (s_awready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_held: awready=%b, required 0", s_awready);
        end
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        checks++;
        if (s_awready !== 1'b1 || s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || wr_pulse_o !== 16'h0 ||
            regs_o !== model_flat() || s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: awready=%b bvalid=%b rvalid=%b pulse=%h rdata=%h, required 1 0 0 0000 0",
                     s_awready, s_bvalid, s_rvalid, wr_pulse_o, s_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_wdata = 32'h13572468; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_bvalid !== 1'b0 || regs_o !== model_flat()) begin
                errors++;
                $display("FAIL rst_mid_no_b[%0d]: bvalid=%b, required 0", i, s_bvalid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_w_before_aw();
        test_partial_strobe();
        test_out_of_range();
        test_back_to_back();
        test_b_stall();
        test_prot();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
